// File: rtl/dm_sb_pkg.sv
// -----------------------------------------------------------------------------
// dm_sb_pkg
// Shared definitions for the debug-module system-bus responder.
//   SbErrData : read data returned for any out-of-range access
//   SbCntW    : width of the per-entry response countdown
//   sb_rsp_t  : one queued response (data word + error flag)
// -----------------------------------------------------------------------------
package dm_sb_pkg;

   localparam logic [31:0] SbErrData = 32'hBADC_AB1E;

   // Holds RspDelay-1, which is at most 3.
   localparam int SbCntW = 3;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } sb_rsp_t;

   localparam int SbRspW = $bits(sb_rsp_t);

endpackage : dm_sb_pkg

// File: rtl/dm_sb_rsp_fifo.sv
// -----------------------------------------------------------------------------
// dm_sb_rsp_fifo
// Response storage for dm_sb_responder. Each entry carries a payload and a
// countdown. The countdown is loaded with Delay-1 on push and decrements every
// cycle. The head retires (pop_o) in the cycle its countdown reads zero.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (empties the queue)
//   push_i         enqueue push_data_i (legal when full only if pop_o is set)
//   push_data_i    entry payload
//   full_o         all Depth entries occupied
//   pop_o          head entry is due and retires this cycle
//   head_data_o    payload of the head entry
// -----------------------------------------------------------------------------
module dm_sb_rsp_fifo
   import dm_sb_pkg::*;
#(
   parameter int Depth = 2,
   parameter int Width = SbRspW,
   parameter int Delay = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   output logic             full_o,
   output logic             pop_o,
   output logic [Width-1:0] head_data_o
);

   localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntQW = $clog2(Depth + 1);

   localparam logic [PtrW-1:0]   LastPtr = PtrW'(Depth - 1);
   localparam logic [PtrW-1:0]   PtrOne  = PtrW'(1);
   localparam logic [CntQW-1:0]  DepthC  = CntQW'(Depth);
   localparam logic [CntQW-1:0]  CountOne = CntQW'(1);
   localparam logic [SbCntW-1:0] Reload  = SbCntW'(Delay - 1);
   localparam logic [SbCntW-1:0] CdOne   = SbCntW'(1);

   logic [Width-1:0]  data_q [Depth];
   logic [SbCntW-1:0] cd_q   [Depth];
   logic [PtrW-1:0]   rd_ptr_q;
   logic [PtrW-1:0]   wr_ptr_q;
   logic [CntQW-1:0]  count_q;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrOne;
   endfunction

   assign full_o      = (count_q == DepthC);
   assign pop_o       = (count_q != '0) && (cd_q[rd_ptr_q] == '0);
   assign head_data_o = data_q[rd_ptr_q];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_o)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push_i, pop_o})
            2'b10:   count_q <= count_q + CountOne;
            2'b01:   count_q <= count_q - CountOne;
            default: ;
         endcase
      end
   end

   // NOTE: payload and countdown storage is deliberately not reset; occupancy
   // is tracked only by the pointers and count, so stale slots are harmless.
   // A push into the slot being popped (full + pop) overwrites it at the edge,
   // after the head has been presented this cycle.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < Depth; i++) begin
         if (cd_q[i] != '0) cd_q[i] <= cd_q[i] - CdOne;
      end
      if (push_i) begin
         data_q[wr_ptr_q] <= push_data_i;
         cd_q[wr_ptr_q]   <= Reload;
      end
   end

endmodule : dm_sb_rsp_fifo

// File: rtl/dm_sb_responder.sv
// -----------------------------------------------------------------------------
// dm_sb_responder
// System-bus slave model for the debug module: a word-addressed memory with
// byte enables, a configurable grant delay, a fixed response latency and a
// small queue of outstanding responses. Out-of-range accesses leave memory
// untouched and answer with SbErrData and err_o=1.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_i          request from the bus master
//   addr_i         byte address (bits [1:0] ignored)
//   we_i, be_i     write enable, byte enables
//   wdata_i        write data
//   gnt_o          request accepted this cycle
//   rvalid_o       response valid (one cycle per grant, in grant order)
//   rdata_o        response data (0 when rvalid_o=0)
//   err_o          response error (0 when rvalid_o=0)
// -----------------------------------------------------------------------------
module dm_sb_responder
   import dm_sb_pkg::*;
#(
   parameter logic [31:0] BaseAddr = 32'h0000_0000,
   parameter int          MemWords = 1024,
   parameter int          GntDelay = 0,
   parameter int          RspDelay = 1,
   parameter int          Depth    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int          AW        = (MemWords > 1) ? $clog2(MemWords) : 1;
   localparam logic [31:0] MemWordsW = 32'(MemWords);
   localparam logic [2:0]  GntLimit  = 3'(GntDelay);
   localparam logic [2:0]  WaitOne   = 3'(1);

   logic [31:0]       mem [MemWords];
   logic [31:0]       offset;
   logic              in_range;
   logic [AW-1:0]     word_idx;
   logic [31:0]       rd_word;
   logic              unused_offset_lsbs;

   logic [2:0]        wait_q;
   logic              gnt;
   logic              fifo_full;
   logic              fifo_pop;
   sb_rsp_t           push_rsp;
   sb_rsp_t           head_rsp;
   logic [SbRspW-1:0] head_bits;

   // Range check on the word part of the offset: equivalent to
   // offset < 4*MemWords without needing a 34-bit constant.
   assign offset             = addr_i - BaseAddr;
   assign in_range           = {2'b00, offset[31:2]} < MemWordsW;
   assign word_idx           = offset[AW+1:2];
   assign unused_offset_lsbs = ^offset[1:0];
   assign rd_word            = mem[word_idx];

   // A full queue still accepts a grant when its head retires this cycle.
   assign gnt   = req_i && !rst_i && (wait_q == GntLimit) && (!fifo_full || fifo_pop);
   assign gnt_o = gnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || !req_i || gnt) begin
         wait_q <= '0;
      end else if (wait_q != GntLimit) begin
         wait_q <= wait_q + WaitOne;
      end
   end

   // NOTE: every variable driven here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      push_rsp = '0;
      if (!in_range) begin
         push_rsp.rdata = SbErrData;
         push_rsp.err   = 1'b1;
      end else if (!we_i) begin
         push_rsp.rdata = rd_word;
      end
   end

   // Memory contents survive reset; gnt is already low while rst_i is high.
   always_ff @(posedge clk_i) begin
      if (gnt && we_i && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   dm_sb_rsp_fifo #(
      .Depth (Depth),
      .Width (SbRspW),
      .Delay (RspDelay)
   ) u_rsp_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (gnt),
      .push_data_i (push_rsp),
      .full_o      (fifo_full),
      .pop_o       (fifo_pop),
      .head_data_o (head_bits)
   );

   assign head_rsp = sb_rsp_t'(head_bits);

   // In-flight responses are discarded by reset, including one due this cycle.
   assign rvalid_o = fifo_pop && !rst_i;
   assign rdata_o  = rvalid_o ? head_rsp.rdata : 32'h0;
   assign err_o    = rvalid_o && head_rsp.err;

endmodule : dm_sb_responder

// File: tb/tb_dm_sb_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_sb_responder
// Five responder instances with different parameter sets share one clock:
//   0: full defaults (MemWords=1024)       range / error responses
//   1: MemWords=2048                       write/read and byte enables at 0x1000
//   2: GntDelay=3                          grant delay and dropped requests
//   3: RspDelay=4, Depth=2                 back-to-back grants under a full queue
//   4: RspDelay=2                          reset with a response in flight
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_dm_sb_responder;

   typedef logic [31:0] w4_t [4];
   typedef int          i4_t [4];

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   logic        clk;
   logic        rst    [5];
   logic        req    [5];
   logic [31:0] addr   [5];
   logic        we     [5];
   logic [3:0]  be     [5];
   logic [31:0] wdata  [5];
   logic        gnt    [5];
   logic        rvalid [5];
   logic [31:0] rdata  [5];
   logic        err    [5];

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dm_sb_responder u_dut0 (
      .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
      .be_i(be[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .err_o(err[0]));

   dm_sb_responder #(.MemWords(2048)) u_dut1 (
      .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
      .be_i(be[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .err_o(err[1]));

   dm_sb_responder #(.GntDelay(3)) u_dut2 (
      .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .addr_i(addr[2]), .we_i(we[2]),
      .be_i(be[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
      .rdata_o(rdata[2]), .err_o(err[2]));

   dm_sb_responder #(.RspDelay(4), .Depth(2)) u_dut3 (
      .clk_i(clk), .rst_i(rst[3]), .req_i(req[3]), .addr_i(addr[3]), .we_i(we[3]),
      .be_i(be[3]), .wdata_i(wdata[3]), .gnt_o(gnt[3]), .rvalid_o(rvalid[3]),
      .rdata_o(rdata[3]), .err_o(err[3]));

   dm_sb_responder #(.RspDelay(2)) u_dut4 (
      .clk_i(clk), .rst_i(rst[4]), .req_i(req[4]), .addr_i(addr[4]), .we_i(we[4]),
      .be_i(be[4]), .wdata_i(wdata[4]), .gnt_o(gnt[4]), .rvalid_o(rvalid[4]),
      .rdata_o(rdata[4]), .err_o(err[4]));

   // One request on a GntDelay=0 / RspDelay=1 instance: grant sampled in the
   // request cycle, response sampled in the following cycle.
   task automatic run_single(input int k, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d,
                             output logic g, output logic v,
                             output logic [31:0] rd, output logic e);
      req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
      @(negedge clk);
      g = gnt[k];
      @(posedge clk); #1;
      req[k] = 1'b0;
      @(negedge clk);
      v = rvalid[k]; rd = rdata[k]; e = err[k];
      @(posedge clk); #1;
   endtask

   // Holds req for each of n requests until granted; records grant and
   // response cycles (relative to the first request cycle) for 14 cycles.
   task automatic stream(input int k, input int n, input logic w,
                         input w4_t a, input w4_t d,
                         output i4_t gc, output i4_t vc, output w4_t vd,
                         output logic [3:0] ve, output int vn);
      int gi;
      gi = 0; vn = 0; ve = '0;
      for (int i = 0; i < 4; i++) begin
         gc[i] = -1; vc[i] = -1; vd[i] = '0;
      end
      for (int c = 0; c < 14; c++) begin
         if (gi < n) begin
            req[k] = 1'b1; we[k] = w; addr[k] = a[gi]; be[k] = 4'hF; wdata[k] = d[gi];
         end else begin
            req[k] = 1'b0;
         end
         @(negedge clk);
         if (rvalid[k]) begin
            if (vn < 4) begin
               vc[vn] = c; vd[vn] = rdata[k]; ve[vn] = err[k];
            end
            vn++;
         end
         if (gnt[k] && gi < 4) begin
            gc[gi] = c;
            gi++;
         end
         @(posedge clk); #1;
      end
      req[k] = 1'b0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 5; k++) begin
         req[k] = 1'b1; we[k] = 1'b1; addr[k] = 32'h0; be[k] = 4'hF; wdata[k] = 32'h0;
      end
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if ({gnt[k], rvalid[k], rdata[k], err[k]} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_active[%0d] got gnt=%b rvalid=%b rdata=%h err=%b, want all 0",
                     k, gnt[k], rvalid[k], rdata[k], err[k]);
         end
      end
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         req[k] = 1'b0; rst[k] = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if ({gnt[k], rvalid[k], rdata[k], err[k]} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_idle[%0d] got gnt=%b rvalid=%b rdata=%h err=%b, want all 0",
                     k, gnt[k], rvalid[k], rdata[k], err[k]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_read_write();
      vec_t tbl [6];
      logic g, v, e;
      logic [31:0] rd;
      tbl[0] = '{1'b1, 32'h0000_1000, 4'hF,    32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tbl[1] = '{1'b0, 32'h0000_1000, 4'h0,    32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      tbl[2] = '{1'b1, 32'h0000_1000, 4'b0101, 32'h1122_3344, 32'h0000_0000, 1'b0};
      tbl[3] = '{1'b0, 32'h0000_1000, 4'hF,    32'h0000_0000, 32'hDE22_BE44, 1'b0};
      tbl[4] = '{1'b1, 32'h0000_1000, 4'b1010, 32'h5566_7788, 32'h0000_0000, 1'b0};
      tbl[5] = '{1'b0, 32'h0000_1000, 4'hF,    32'h0000_0000, 32'h5522_7744, 1'b0};
      for (int i = 0; i < 6; i++) begin
         run_single(1, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, g, v, rd, e);
         n_tests++;
         if ({g, v, rd, e} !== {1'b1, 1'b1, tbl[i].exp_rd, tbl[i].exp_err}) begin
            n_fail++;
            $display("FAIL rw[%0d] got gnt=%b rvalid=%b rdata=%h err=%b, want gnt=1 rvalid=1 rdata=%h err=%b",
                     i, g, v, rd, e, tbl[i].exp_rd, tbl[i].exp_err);
         end
      end
      @(negedge clk);
      n_tests++;
      if ({rvalid[1], rdata[1], err[1]} !== 34'h0) begin
         n_fail++;
         $display("FAIL rw_idle got rvalid=%b rdata=%h err=%b, want all 0", rvalid[1], rdata[1], err[1]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_out_of_range();
      vec_t tbl [8];
      logic g, v, e;
      logic [31:0] rd;
      tbl[0] = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      tbl[1] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0};
      tbl[2] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0000_0000, 32'hBADC_AB1E, 1'b1};
      tbl[3] = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'hBADC_AB1E, 1'b1};
      tbl[4] = '{1'b0, 32'h0000_0002, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
      tbl[5] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0};
      tbl[6] = '{1'b1, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 32'hBADC_AB1E, 1'b1};
      tbl[7] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
      for (int i = 0; i < 8; i++) begin
         run_single(0, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, g, v, rd, e);
         n_tests++;
         if ({g, v, rd, e} !== {1'b1, 1'b1, tbl[i].exp_rd, tbl[i].exp_err}) begin
            n_fail++;
            $display("FAIL oor[%0d] got gnt=%b rvalid=%b rdata=%h err=%b, want gnt=1 rvalid=1 rdata=%h err=%b",
                     i, g, v, rd, e, tbl[i].exp_rd, tbl[i].exp_err);
         end
      end
   endtask

   task automatic test_gnt_delay();
      w4_t a, d, vd;
      i4_t gc, vc;
      logic [3:0] ve;
      int vn;
      logic any_gnt, any_rsp;
      a = '{32'h10, 32'h0, 32'h0, 32'h0};
      d = '{32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0};
      stream(2, 1, 1'b1, a, d, gc, vc, vd, ve, vn);
      n_tests++;
      if (gc[0] != 3 || vc[0] != 4 || vn != 1 || vd[0] !== 32'h0 || ve[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL gnt_delay_write got gnt_cyc=%0d rsp_cyc=%0d n_rsp=%0d rdata=%h err=%b, want 3 4 1 00000000 0",
                  gc[0], vc[0], vn, vd[0], ve[0]);
      end
      // Request withdrawn after two cycles: no grant, no response, no write.
      any_gnt = 1'b0; any_rsp = 1'b0;
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h10; be[2] = 4'hF; wdata[2] = 32'h0;
      for (int c = 0; c < 8; c++) begin
         if (c == 2) req[2] = 1'b0;
         @(negedge clk);
         any_gnt |= gnt[2];
         any_rsp |= rvalid[2];
         @(posedge clk); #1;
      end
      n_tests++;
      if ({any_gnt, any_rsp} !== 2'b00) begin
         n_fail++;
         $display("FAIL gnt_delay_drop got gnt_seen=%b rvalid_seen=%b, want 0 0", any_gnt, any_rsp);
      end
      stream(2, 1, 1'b0, a, d, gc, vc, vd, ve, vn);
      n_tests++;
      if (gc[0] != 3 || vc[0] != 4 || vn != 1 || vd[0] !== 32'hA5A5_A5A5 || ve[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL gnt_delay_read got gnt_cyc=%0d rsp_cyc=%0d n_rsp=%0d rdata=%h err=%b, want 3 4 1 a5a5a5a5 0",
                  gc[0], vc[0], vn, vd[0], ve[0]);
      end
   endtask

   task automatic test_back_to_back();
      w4_t a, d, vd;
      i4_t gc, vc, exp_g, exp_v;
      logic [3:0] ve;
      int vn;
      a     = '{32'h20, 32'h24, 32'h28, 32'h2C};
      d     = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
      exp_g = '{0, 1, 4, 5};
      exp_v = '{4, 5, 8, 9};
      stream(3, 4, 1'b1, a, d, gc, vc, vd, ve, vn);
      n_tests++;
      if (vn != 4 || gc != exp_g || vc != exp_v || ve !== 4'h0) begin
         n_fail++;
         $display("FAIL b2b_write got n_rsp=%0d gnt=%0d,%0d,%0d,%0d rsp=%0d,%0d,%0d,%0d err=%b, want 4 0,1,4,5 4,5,8,9 0000",
                  vn, gc[0], gc[1], gc[2], gc[3], vc[0], vc[1], vc[2], vc[3], ve);
      end
      stream(3, 4, 1'b0, a, d, gc, vc, vd, ve, vn);
      n_tests++;
      if (vn != 4) begin
         n_fail++;
         $display("FAIL b2b_count got %0d responses, want 4", vn);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (gc[i] != exp_g[i] || vc[i] != exp_v[i] || vd[i] !== d[i] || ve[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_read[%0d] got gnt_cyc=%0d rsp_cyc=%0d rdata=%h err=%b, want %0d %0d %h 0",
                     i, gc[i], vc[i], vd[i], ve[i], exp_g[i], exp_v[i], d[i]);
         end
      end
   endtask

   task automatic test_reset_inflight();
      w4_t a, d, vd;
      i4_t gc, vc;
      logic [3:0] ve;
      int vn;
      logic g, v_rst, any_rsp;
      a = '{32'h40, 32'h0, 32'h0, 32'h0};
      d = '{32'h0BAD_F00D, 32'h0, 32'h0, 32'h0};
      stream(4, 1, 1'b1, a, d, gc, vc, vd, ve, vn);
      n_tests++;
      if (gc[0] != 0 || vc[0] != 2 || vn != 1) begin
         n_fail++;
         $display("FAIL inflight_pre got gnt_cyc=%0d rsp_cyc=%0d n_rsp=%0d, want 0 2 1", gc[0], vc[0], vn);
      end
      req[4] = 1'b1; we[4] = 1'b0; addr[4] = 32'h40; be[4] = 4'hF;
      @(negedge clk);
      g = gnt[4];
      @(posedge clk); #1;
      req[4] = 1'b0; rst[4] = 1'b1;
      @(negedge clk);
      v_rst = rvalid[4];
      @(posedge clk); #1;
      rst[4] = 1'b0;
      any_rsp = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         any_rsp |= rvalid[4] | err[4] | (rdata[4] != 32'h0);
         @(posedge clk); #1;
      end
      n_tests++;
      if ({g, v_rst, any_rsp} !== 3'b100) begin
         n_fail++;
         $display("FAIL inflight_reset got gnt=%b rvalid_in_reset=%b rsp_after=%b, want 1 0 0", g, v_rst, any_rsp);
      end
      stream(4, 1, 1'b0, a, d, gc, vc, vd, ve, vn);
      n_tests++;
      if (gc[0] != 0 || vc[0] != 2 || vn != 1 || vd[0] !== 32'h0BAD_F00D || ve[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL inflight_post got gnt_cyc=%0d rsp_cyc=%0d n_rsp=%0d rdata=%h err=%b, want 0 2 1 0badf00d 0",
                  gc[0], vc[0], vn, vd[0], ve[0]);
      end
   endtask

   initial begin
      for (int k = 0; k < 5; k++) begin
         rst[k] = 1'b1; req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; be[k] = '0; wdata[k] = '0;
      end
      @(posedge clk); #1;
      test_reset();
      test_read_write();
      test_out_of_range();
      test_gnt_delay();
      test_back_to_back();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_dm_sb_responder
